// File: rtl/integrator_mc.sv
// Multi-channel saturating fixed-point integrator: v[i] += (a[i]*dt) >>> FRAC per step,
// sequenced through one shared LSB-first shift-add multiplier.
module integrator_mc #(
  parameter int WIDTH    = 16,
  parameter int FRAC     = 8,
  parameter int CHANNELS = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         clear,
  input  logic [CHANNELS*WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]             dt,
  output logic [CHANNELS*WIDTH-1:0]    v,
  output logic                         busy,
  output logic                         done,
  output logic [CHANNELS-1:0]          sat
);

  localparam int PW   = 2 * WIDTH;
  localparam int SW   = 2 * WIDTH + 1;
  localparam int IW   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int CNTW = $clog2(WIDTH);

  localparam logic signed [SW-1:0] VMAX = {{(SW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0] VMIN = {{(SW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_ACC, S_DONE} state_t;

  function automatic logic signed [PW-1:0] sext(input logic [WIDTH-1:0] x);
    return {{WIDTH{x[WIDTH-1]}}, x};
  endfunction

  function automatic logic signed [WIDTH-1:0] sat_clamp(input logic signed [SW-1:0] s);
    if (s > VMAX)      return VMAX[WIDTH-1:0];
    else if (s < VMIN) return VMIN[WIDTH-1:0];
    else               return s[WIDTH-1:0];
  endfunction

  function automatic logic sat_ovf(input logic signed [SW-1:0] s);
    return (s > VMAX) || (s < VMIN);
  endfunction

  state_t                      state_q;
  logic [IW-1:0]               idx_q;
  logic [CNTW-1:0]             cnt_q;
  logic [CHANNELS*WIDTH-1:0]   a_sh_q;
  logic [WIDTH-1:0]            dt_sh_q;
  logic signed [PW-1:0]        mcand_q;
  logic [WIDTH-1:0]            mplier_q;
  logic signed [PW-1:0]        prod_q;
  logic signed [WIDTH-1:0]     v_q [CHANNELS];
  logic [CHANNELS-1:0]         sat_q;
  logic                        busy_q;
  logic                        done_q;

  logic signed [WIDTH-1:0]     acc_cur;
  logic signed [PW-1:0]        prod_sh;
  logic signed [SW-1:0]        sum_d;
  logic signed [WIDTH-1:0]     clamp_d;
  logic                        ovf_d;
  logic [IW-1:0]               nxt_idx;
  logic [WIDTH-1:0]            a_next;

  // Accumulate stage: widened add of the floored product, then clamp.
  always_comb begin
    acc_cur = v_q[idx_q];
    prod_sh = prod_q >>> FRAC;
    sum_d   = {{(SW-WIDTH){acc_cur[WIDTH-1]}}, acc_cur} + {prod_sh[PW-1], prod_sh};
    clamp_d = sat_clamp(sum_d);
    ovf_d   = sat_ovf(sum_d);
    nxt_idx = idx_q + 1'b1;
    a_next  = a_sh_q[int'(nxt_idx)*WIDTH +: WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      a_sh_q   <= '0;
      dt_sh_q  <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      sat_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) v_q[i] <= '0;
    end else if (clear) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      sat_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) v_q[i] <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            a_sh_q   <= a;
            dt_sh_q  <= dt;
            idx_q    <= '0;
            mcand_q  <= sext(a[WIDTH-1:0]);
            mplier_q <= dt;
            prod_q   <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= S_MUL;
          end
        end
        // One multiplier bit per cycle; the multiplicand doubles as dt shifts down.
        S_MUL: begin
          if (mplier_q[0]) prod_q <= prod_q + mcand_q;
          mcand_q  <= mcand_q <<< 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == CNTW'(WIDTH-1)) state_q <= S_ACC;
        end
        S_ACC: begin
          v_q[idx_q] <= clamp_d;
          if (ovf_d) sat_q[idx_q] <= 1'b1;
          if (idx_q == IW'(CHANNELS-1)) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            idx_q    <= nxt_idx;
            mcand_q  <= sext(a_next);
            mplier_q <= dt_sh_q;
            prod_q   <= '0;
            cnt_q    <= '0;
            state_q  <= S_MUL;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_vout
    assign v[g*WIDTH +: WIDTH] = v_q[g];
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sat  = sat_q;

endmodule

// File: tb/tb_integrator_mc.sv
// Bench for integrator_mc: timeline-level reference model checked every cycle,
// plus directed steps with hand-computed velocities, latencies and pulse counts.
module tb_integrator_mc;

  localparam int W   = 16;
  localparam int FR  = 8;
  localparam int CH  = 2;
  localparam int LAT = CH * (W + 1);

  logic              clk = 1'b0;
  logic              rst, start, clear;
  logic [CH*W-1:0]   a;
  logic [W-1:0]      dt;
  logic [CH*W-1:0]   v;
  logic              busy, done;
  logic [CH-1:0]     sat;

  integrator_mc #(.WIDTH(W), .FRAC(FR), .CHANNELS(CH)) dut (
    .clk(clk), .rst(rst), .start(start), .clear(clear),
    .a(a), .dt(dt), .v(v), .busy(busy), .done(done), .sat(sat)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: tracks edges since the accepted start and applies
  // each channel's update at its scheduled edge using plain integer math.
  int          t = -1;
  longint      mv [CH];
  logic [CH-1:0] msat;
  bit          mbusy, mdone;
  logic [CH*W-1:0] ma;
  logic [W-1:0]    mdt;

  function automatic longint floordiv(input longint p, input longint d);
    longint q;
    q = p / d;
    if ((p % d) != 0 && p < 0) q = q - 1;
    return q;
  endfunction

  task automatic model_update(input int i);
    longint ai, p, s;
    logic [W-1:0] araw;
    araw = ma[i*W +: W];
    ai = longint'($signed(araw));
    p  = ai * longint'(mdt);
    s  = mv[i] + floordiv(p, longint'(1) << FR);
    if (s > 32767)       begin s = 32767;  msat[i] = 1'b1; end
    else if (s < -32768) begin s = -32768; msat[i] = 1'b1; end
    mv[i] = s;
  endtask

  always @(posedge clk) begin
    mdone = 1'b0;
    if (rst || clear) begin
      t = -1; mbusy = 1'b0; msat = '0;
      for (int i = 0; i < CH; i++) mv[i] = 0;
    end else if (t < 0) begin
      if (start) begin
        ma = a; mdt = dt; t = 0; mbusy = 1'b1;
      end
    end else begin
      t++;
      for (int i = 0; i < CH; i++) if (t == (i + 1) * (W + 1)) model_update(i);
      if (t == LAT) begin mdone = 1'b1; mbusy = 1'b0; end
      else if (t == LAT + 1) t = -1;
    end
  end

  always @(negedge clk) begin
    logic [CH*W-1:0] vexp;
    logic [63:0] tmp;
    if (done === 1'b1) done_cnt++;
    if (chk_en) begin
      for (int i = 0; i < CH; i++) begin
        tmp = 64'(mv[i]);
        vexp[i*W +: W] = tmp[W-1:0];
      end
      chk("model_v", 64'(v), 64'(vexp));
      chk("model_busy", 64'(busy), 64'(mbusy));
      chk("model_done", 64'(done), 64'(mdone));
      chk("model_sat", 64'(sat), 64'(msat));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Pulses start, scrambles the inputs after capture, and measures cycles to done.
  task automatic step(input logic [CH*W-1:0] av, input logic [W-1:0] dv, output int lat);
    @(negedge clk); a = av; dt = dv; start = 1'b1;
    @(negedge clk); start = 1'b0; a = ~av; dt = ~dv; lat = 1;
    while (done !== 1'b1 && lat < 200) begin
      @(negedge clk); lat++;
    end
  endtask

  localparam logic [CH*W-1:0] A_BASIC = {16'hFF56, 16'h00AA};
  localparam logic [CH*W-1:0] A_SAT   = {16'h8000, 16'h7FFF};

  initial begin
    int lat, dc;
    rst = 1'b1; start = 1'b0; clear = 1'b0; a = '0; dt = '0;
    tick(2);
    chk_en = 1'b1;
    tick(8);
    chk("reset_v", 64'(v), 64'h0);
    chk("reset_busy_done", 64'({busy, done}), 64'h0);
    chk("reset_sat", 64'(sat), 64'h0);
    rst = 1'b0;
    tick(2);

    step(A_BASIC, 16'd10, lat);
    chk("basic_latency", 64'(lat), 64'd35);
    chk("basic_v", 64'(v), 64'hFFF9_0006);
    chk("basic_sat", 64'(sat), 64'h0);
    for (int k = 0; k < 3; k++) step(A_BASIC, 16'd10, lat);
    tick(1);
    chk("accum_v", 64'(v), 64'hFFE4_0018);

    step(A_SAT, 16'hFFFF, lat);
    chk("sat_v", 64'(v), 64'h8000_7FFF);
    chk("sat_flags", 64'(sat), 64'h3);
    step(A_BASIC, 16'd0, lat);
    chk("dt0_latency", 64'(lat), 64'd35);
    chk("dt0_v", 64'(v), 64'h8000_7FFF);
    chk("dt0_sat_sticky", 64'(sat), 64'h3);

    // start pulsed again while busy must be ignored
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    dc = done_cnt;
    @(negedge clk); a = A_BASIC; dt = 16'd10; start = 1'b1;
    @(negedge clk); start = 1'b0; lat = 1;
    tick(4); start = 1'b1;
    @(negedge clk); start = 1'b0; lat += 5;
    while (done !== 1'b1 && lat < 200) begin @(negedge clk); lat++; end
    chk("busy_start_latency", 64'(lat), 64'd35);
    tick(45);
    chk("busy_start_done_cnt", 64'(done_cnt - dc), 64'd1);
    chk("busy_start_v", 64'(v), 64'hFFF9_0006);

    // clear after the ch0 update
    @(negedge clk); a = A_BASIC; dt = 16'd10; start = 1'b1;
    @(negedge clk); start = 1'b0;
    tick(18);
    chk("pre_clear_v0", 64'(v[15:0]), 64'h000C);
    dc = done_cnt;
    clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    chk("clear_v", 64'(v), 64'h0);
    chk("clear_busy_sat", 64'({busy, sat}), 64'h0);
    tick(45);
    chk("clear_no_done", 64'(done_cnt - dc), 64'd0);
    step(A_BASIC, 16'd10, lat);
    chk("post_clear_latency", 64'(lat), 64'd35);
    chk("post_clear_v", 64'(v), 64'hFFF9_0006);

    // reset during the multiply
    @(negedge clk); a = A_SAT; dt = 16'hFFFF; start = 1'b1;
    @(negedge clk); start = 1'b0;
    tick(4); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("rst_mid_outputs", 64'({v, busy, done, sat}), 64'h0);

    // start and clear together in IDLE
    step(A_BASIC, 16'd10, lat);
    tick(2);
    start = 1'b1; clear = 1'b1;
    @(negedge clk); start = 1'b0; clear = 1'b0;
    chk("start_clear_busy", 64'(busy), 64'h0);
    chk("start_clear_v", 64'(v), 64'h0);
    @(negedge clk);
    chk("start_clear_busy2", 64'(busy), 64'h0);
    tick(40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
